// File: rtl/seven_seg_mux_if.sv
// seven_seg_mux_if: user-side data and display-pin signals of the seven-segment driver
interface seven_seg_mux_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] values;
  logic [DIGITS-1:0] dp, blank, sel;
  logic lzb, load;
  logic [3:0] bright;
  logic [7:0] seg;
  modport master(output values, dp, blank, lzb, bright, load, input sel, seg);
  modport slave(input values, dp, blank, lzb, bright, load, output sel, seg);
endinterface

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: scanned hex seven-segment driver with shadowed data, leading-zero/per-digit blanking and duty dimming
module seven_seg_mux #(
  parameter int DIGITS = 4,
  parameter int DIV = 16,
  parameter bit ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  seven_seg_mux_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [DIV-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] sh_values;
  logic [DIGITS-1:0] sh_dp, sh_blank, sel_d, zero_up;
  logic sh_lzb, lit, acc;
  logic [3:0] nib;
  logic [7:0] seg_d;
  // zero_up[i]: digit i and every digit above it are zero
  always_comb begin
    acc = 1'b1;
    zero_up = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc && sh_values[4*i+:4] == 4'h0;
      zero_up[i] = acc;
    end
    nib = sh_values[{idx, 2'b00}+:4];
    lit = !sh_blank[idx] && !(sh_lzb && idx != '0 && zero_up[idx]) && cnt[DIV-1-:4] < bus.bright;
    for (int i = 0; i < DIGITS; i++) sel_d[i] = lit && idx == IW'(i);
    seg_d = lit ? {sh_dp[idx], HEX[nib]} : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      sh_values <= '0;
      sh_dp <= '0;
      sh_blank <= '0;
      sh_lzb <= 1'b0;
      bus.sel <= {DIGITS{ACTIVE_LOW}};
      bus.seg <= {8{ACTIVE_LOW}};
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (bus.load) begin
        sh_values <= bus.values;
        sh_dp <= bus.dp;
        sh_blank <= bus.blank;
        sh_lzb <= bus.lzb;
      end
      bus.sel <= ACTIVE_LOW ? ~sel_d : sel_d;
      bus.seg <= ACTIVE_LOW ? ~seg_d : seg_d;
    end
  end
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: scoreboard bench comparing 4-digit active-low and 3-digit active-high instances to a slot/phase model
module tb_seven_seg_mux;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [15:0] values = '0;
  logic [3:0] dp = '0, blank = '0, bright = '0;
  logic lzb = 1'b0, load = 1'b0;
  int vectors = 0, miscompares = 0, k = 0;
  logic [15:0] m_v;
  logic [3:0] m_dp, m_bl;
  logic m_lzb;
  logic [22:0] q[$];
  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_mux_if #(.DIGITS(4)) b4();
  seven_seg_mux_if #(.DIGITS(3)) b3();
  assign b4.values = values;
  assign b4.dp = dp;
  assign b4.blank = blank;
  assign b4.lzb = lzb;
  assign b4.bright = bright;
  assign b4.load = load;
  assign b3.values = values[11:0];
  assign b3.dp = dp[2:0];
  assign b3.blank = blank[2:0];
  assign b3.lzb = lzb;
  assign b3.bright = bright;
  assign b3.load = load;

  seven_seg_mux #(.DIGITS(4), .DIV(5), .ACTIVE_LOW(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  seven_seg_mux #(.DIGITS(3), .DIV(5), .ACTIVE_LOW(0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  always #5 clk = ~clk;

  // Expected {sel, seg} for cycle k of the scan: slot = k/32 picks the digit, phase/2 is the duty step
  function automatic logic [15:0] expect_out(input int d, input bit al, input int kk, input logic [15:0] v,
                                             input logic [3:0] p, input logic [3:0] bl, input logic z,
                                             input logic [3:0] br);
    int i, ph;
    logic [15:0] vm;
    logic [7:0] sl, sg;
    logic lit, supp;
    i = (kk / 32) % d;
    ph = kk % 32;
    vm = (d == 4) ? v : {4'h0, v[11:0]};
    supp = z && i > 0 && (vm >> (4 * i)) == 16'h0;
    lit = !bl[i] && !supp && (ph / 2 < int'(br));
    sg = lit ? {p[i], hex[4'(vm >> (4 * i))]} : 8'h00;
    sl = lit ? 8'(1 << i) : 8'h00;
    if (al) begin
      sl = ~sl & 8'((1 << d) - 1);
      sg = ~sg;
    end
    return {sl, sg};
  endfunction

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h expected=%h", n, $time, act, exp);
    end
  endtask

  // Reference model: one expected entry per active edge
  initial begin
    logic [15:0] e4, e3;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        m_v = '0;
        m_dp = '0;
        m_bl = '0;
        m_lzb = 1'b0;
        q.push_back({4'hF, 8'hFF, 3'h0, 8'h00});
      end else begin
        e4 = expect_out(4, 1'b1, k, m_v, m_dp, m_bl, m_lzb, bright);
        e3 = expect_out(3, 1'b0, k, m_v, m_dp, m_bl, m_lzb, bright);
        q.push_back({e4[11:8], e4[7:0], e3[10:8], e3[7:0]});
        if (load) begin
          m_v = values;
          m_dp = dp;
          m_bl = blank;
          m_lzb = lzb;
        end
        k++;
      end
    end
  end

  // Monitor: pops and compares after every registered output update
  initial begin
    logic [22:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL queue_empty t=%0t got=none expected=entry", $time);
      end else begin
        e = q.pop_front();
        chk("sel4", {4'h0, b4.sel}, {4'h0, e[22:19]});
        chk("seg4", b4.seg, e[18:11]);
        chk("sel3", {5'h0, b3.sel}, {5'h0, e[10:8]});
        chk("seg3", b3.seg, e[7:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] bl, input logic z);
    @(negedge clk);
    values = v;
    dp = p;
    blank = bl;
    lzb = z;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    bright = 4'd15;
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    idle(140);
    bright = 4'd0;
    idle(64);
    bright = 4'd1;
    idle(140);
    bright = 4'd15;
    do_load(16'h0040, 4'h0, 4'h0, 1'b1);
    idle(130);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    idle(130);
    @(negedge clk);
    values = 16'h5555;
    idle(40);
    do_load(16'h1234, 4'b0001, 4'b0100, 1'b0);
    idle(140);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      values = 16'(16'h0F0F + i);
      load = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;
    idle(50);
    // Asynchronous reset between edges must darken both displays at once
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel4", {4'h0, b4.sel}, 8'h0F);
    chk("rst_seg4", b4.seg, 8'hFF);
    chk("rst_sel3", {5'h0, b3.sel}, 8'h00);
    chk("rst_seg3", b3.seg, 8'h00);
    idle(2);
    rst_n = 1'b1;
    do_load(16'h0907, 4'b1010, 4'h0, 1'b1);
    idle(100);
    repeat (2000) begin
      @(negedge clk);
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        for (int j = 0; j < 4; j++) values[4*j+:4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        dp = 4'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lzb = 1'($urandom);
      end
      if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
    end
    load = 1'b0;
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Parametrised, multiplexed seven-segment display driver for the Io-board digit/segment outputs (`io_sel`, `io_seg`). It replaces direct top-level tie-offs with a scanned, hex-decoding driver. Features: any digit count, atomic value loading, leading-zero blanking, per-digit blanking, decimal points and 16-step brightness. It sits between user logic and the display pins, and runs on the board clock under the board reset.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; legal range 1–8.
- `DIV`, 16: slot counter width; each digit is shown for 2^DIV cycles; legal range 5–24.
- `ACTIVE_LOW`, 1: when 1, `sel` and `seg` are active-low (Io board); when 0, active-high.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `values`  in  4*DIGITS  hex nibble per digit; digit i is `values[4i+3:4i]`; digit 0 is rightmost.
- `dp`  in  DIGITS  decimal point per digit, active-high.
- `blank`  in  DIGITS  force digit dark, active-high.
- `lzb`  in  1  leading-zero blanking enable.
- `bright`  in  4  duty level 0–15.
- `load`  in  1  single-cycle strobe; captures `values`, `dp`, `blank`, `lzb`.
- `sel`  out  DIGITS  digit enables (polarity per `ACTIVE_LOW`).
- `seg`  out  8  segment bus. `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp (polarity per `ACTIVE_LOW`).

## Operation
- **Shadow registers** (`values`, `dp`, `blank`, `lzb`) update only on the clock edge where `load`=1. The display never shows a mix of old and new data. `bright` is not shadowed; it is sampled live.
- **Slot counter** `cnt` (DIV bits) increments every cycle.
- **Digit index** `idx` (0..DIGITS-1) advances when `cnt` wraps from all-ones to 0. It goes DIGITS-1 → 0, which also holds for non-power-of-2 DIGITS.
- **Duty gating:** the digit is lit only while `cnt[DIV-1:DIV-4] < bright`.
  - `bright`=0 keeps the display dark.
  - `bright`=15 lights 15/16 of each slot.
  - The top 1/16 of every slot is always dark, which acts as the anti-ghosting gap.
- **Hex decode** (active-high pattern, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- **Leading-zero blanking:** when shadow `lzb`=1, digit i is suppressed if it and every digit above it are 0. Digit 0 is never suppressed by this rule.
- **Digit dark** when any of the following holds: shadow `blank[idx]`, LZB suppression, or the duty gate is off.
  - A dark digit drives `sel` all-inactive and `seg` all-inactive, including dp.
- **Digit lit:** exactly one `sel` bit is active, at position `idx`. `seg[6:0]` carries the decode and `seg[7]` = shadow `dp[idx]`.
- **Polarity:** if `ACTIVE_LOW`=1, both output buses are inverted after the lit/dark decision.
- No more than one `sel` bit is ever active in any cycle.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - `cnt`=0, `idx`=0, all shadow registers 0.
  - `sel` and `seg` are all-inactive immediately: all-ones if `ACTIVE_LOW`, zeros otherwise.
  - Deassertion is taken synchronously at the next edge; the counter starts from 0.
- **Output latency:** `sel`/`seg` are registered, one cycle after the `cnt`/`idx` state that produced them.
- **Load latency:** `load` at edge N updates the shadow registers at N. Outputs reflect the new data from edge N+1 onward. Total latency from strobe to output is 2 cycles.
- `load` held high reloads every cycle; this is legal.
- **Brightness change** takes effect on the next registered output (1-cycle latency). No glitch beyond a partial slot.
- **Digit-change boundary:** at the `cnt` wrap the duty gate is on (top nibble 0 < `bright` when `bright`≥1). Because the preceding 1/16 slot was dark, the new `sel` never overlaps the old digit's lit period.
- **Reset mid-scan:** outputs go inactive immediately and the scan restarts at digit 0.

## Test plan
Benches use DIV=5, so one slot is 32 cycles and the top-nibble gate changes every 2 cycles.

1. **Reset state.** Assert `rst_n`=0 mid-scan (ACTIVE_LOW=1, DIGITS=4) → `sel`=4'hF and `seg`=8'hFF in the same cycle. After release, the first lit digit is idx 0.
2. **Basic scan.** `values`=16'h12AF, `load` pulse, `bright`=15 → `seg` walks ~8'h8E (F), ~8'h88 (A), ~8'hA4 (2), ~8'hF9 (1). The lit `sel` walks 1110, 1101, 1011, 0111. Each digit is lit 30 of every 32 cycles.
3. **Duty gating.**
   - `bright`=0 → no `sel` bit ever active.
   - `bright`=1 → each digit is lit exactly 2 cycles per 32-cycle slot.
4. **Leading-zero blanking.** `values`=16'h0040, `lzb`=1 → digits 3 and 2 are dark, digit 1 shows "4", digit 0 shows "0".
   - `values`=16'h0000 → only digit 0 is lit, showing "0".
5. **Atomic load and dp/blank.**
   - Change `values` without `load` → display unchanged.
   - Pulse `load` with `dp`=4'b0001 and `blank`=4'b0100 → 2 cycles later, digit 0 has `seg[7]` active and digit 2 is never lit.
6. **Non-power-of-2 width.** DIGITS=3, ACTIVE_LOW=0 → `idx` sequence 0,1,2,0. `sel` is one-hot active-high. `sel` is never 3'b000 during a lit window and never has more than one bit set.
